// File: rtl/arc4_pkg.sv
// Shared ARC4 types: encryptor state encoding, the per-byte keystream
// working set, and common constants for the arc4 block family.
package arc4_pkg;

    localparam logic [7:0] LEN_ADDR = 8'd0;
    localparam int         BYTE_W   = 8;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WR_CT
    } enc_state_t;

    // Working registers for one PRGA step; prga can reuse the same layout.
    typedef struct packed {
        logic [BYTE_W-1:0] i;
        logic [BYTE_W-1:0] j;
        logic [BYTE_W-1:0] si;
        logic [BYTE_W-1:0] sj;
    } keystream_step_t;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed plaintext in pt_mem is XORed with the
// keystream drawn from an already KSA-initialised S, result goes to ct_mem.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int MSG_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    localparam logic [7:0] LEN_CAP = 8'(MSG_MAX);

    enc_state_t      state;
    keystream_step_t ks;
    logic [7:0]      k;
    logic [7:0]      len;
    logic [7:0]      s_addr_q;
    logic [7:0]      len_in;

    // A length byte above MSG_MAX is truncated; with the default cap this is a no-op.
    assign len_in = (pt_rddata > LEN_CAP) ? LEN_CAP : pt_rddata;

    // Paths that consume read data in the same cycle it arrives cannot be
    // registered without adding a cycle per access, so they are muxed here.
    always_comb begin
        s_addr    = s_addr_q;
        s_wrdata  = '0;
        ct_wrdata = '0;
        case (state)
            RD_SJ:   s_addr    = ks.j + s_rddata;
            WR_SI:   s_wrdata  = s_rddata;
            WR_SJ:   s_wrdata  = ks.si;
            WR_LEN:  ct_wrdata = len_in;
            WR_CT:   ct_wrdata = s_rddata ^ pt_rddata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy      <= 1'b1;
            ks       <= '0;
            k        <= '0;
            len      <= '0;
            s_addr_q <= '0;
            s_wren   <= 1'b0;
            pt_addr  <= '0;
            ct_addr  <= '0;
            ct_wren  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RD_LEN;
                        rdy     <= 1'b0;
                        ks      <= '0;
                        pt_addr <= LEN_ADDR;
                    end
                end
                RD_LEN: begin
                    state   <= WR_LEN;
                    ct_addr <= LEN_ADDR;
                    ct_wren <= 1'b1;
                end
                WR_LEN: begin
                    ct_wren <= 1'b0;
                    len     <= len_in;
                    k       <= 8'd1;
                    ks.i    <= 8'd1;
                    if (len_in == 8'd0) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end else begin
                        state    <= RD_SI;
                        s_addr_q <= 8'd1;
                    end
                end
                RD_SI: begin
                    state <= RD_SJ;
                end
                RD_SJ: begin
                    ks.si    <= s_rddata;
                    ks.j     <= ks.j + s_rddata;
                    s_addr_q <= ks.i;
                    s_wren   <= 1'b1;
                    state    <= WR_SI;
                end
                WR_SI: begin
                    ks.sj    <= s_rddata;
                    s_addr_q <= ks.j;
                    s_wren   <= 1'b1;
                    state    <= WR_SJ;
                end
                WR_SJ: begin
                    s_addr_q <= ks.si + ks.sj;
                    s_wren   <= 1'b0;
                    pt_addr  <= k;
                    state    <= RD_PAD;
                end
                RD_PAD: begin
                    ct_addr <= k;
                    ct_wren <= 1'b1;
                    state   <= WR_CT;
                end
                WR_CT: begin
                    ct_wren <= 1'b0;
                    // Compare before increment so len=255 stops without a 256th byte.
                    if (k == len) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end else begin
                        k        <= k + 8'd1;
                        ks.i     <= ks.i + 8'd1;
                        s_addr_q <= ks.i + 8'd1;
                        state    <= RD_SI;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with behavioural S/PT/CT memories and a
// scoreboard of expected ciphertext writes.
module tb_arc4_encrypt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic [7:0] ct_addr;
    logic [7:0] ct_wrdata;
    logic       ct_wren;

    logic [7:0]  s_mem [256];
    logic [7:0]  pt_mem[256];
    logic [7:0]  ct_mem[256];
    logic [7:0]  s_exp [256];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          s_wr_count = 0;

    always #5 clk = ~clk;

    arc4_encrypt #(.MSG_MAX(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
        if (s_wren) s_wr_count <= s_wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every ciphertext write must match the next predicted {addr,data}.
    always @(negedge clk) begin
        if (rst_n && ct_wren) begin
            logic [31:0] want;
            want = (exp_q.size() != 0) ? {16'd0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check("ct_write", {16'd0, ct_addr, ct_wrdata}, want);
            $display("ct write addr=%02h data=%02h", ct_addr, ct_wrdata);
        end
    end

    task automatic s_identity();
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    endtask

    task automatic ct_clear();
        for (int x = 0; x < 256; x++) ct_mem[x] = 8'hEE;
    endtask

    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] jj, t, kb;
        jj = 8'd0;
        s_identity();
        for (int x = 0; x < 256; x++) begin
            case (x % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            jj = 8'(jj + s_mem[x] + kb);
            t = s_mem[x];
            s_mem[x] = s_mem[jj];
            s_mem[jj] = t;
        end
    endtask

    // Reference ARC4 over a copy of S; queues expected writes and final S.
    task automatic predict();
        logic [7:0] sm[256];
        logic [7:0] i, j, t, pad, len;
        for (int x = 0; x < 256; x++) sm[x] = s_mem[x];
        len = pt_mem[0];
        exp_q.push_back({8'd0, len});
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= int'(len); k++) begin
            i = 8'(i + 8'd1);
            j = 8'(j + sm[i]);
            t = sm[i];
            sm[i] = sm[j];
            sm[j] = t;
            pad = sm[8'(sm[i] + sm[j])];
            exp_q.push_back({8'(k), pad ^ pt_mem[k]});
        end
        for (int x = 0; x < 256; x++) s_exp[x] = sm[x];
    endtask

    task automatic start(input string tag);
        @(negedge clk);
        check({tag, "_rdy_idle"}, {31'd0, rdy}, 32'd1);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        check({tag, "_rdy_busy"}, {31'd0, rdy}, 32'd0);
    endtask

    task automatic run(input string tag, input int pulse_at);
        int cyc;
        int bad;
        int len;
        len = int'(pt_mem[0]);
        predict();
        start(tag);
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (rdy) break;
            en = (cyc == pulse_at);
        end
        en = 1'b0;
        check({tag, "_cycles"}, 32'(cyc), 32'(2 + 6 * len));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== s_exp[x]) bad++;
        check({tag, "_s_state"}, 32'(bad), 32'd0);
        $display("%s: len=%0d done in %0d cycles", tag, len, cyc);
    endtask

    initial begin
        int bad;
        int wr0;
        logic [7:0] i, j, t, pad;

        s_identity();
        ct_clear();
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;

        @(posedge clk);
        #2;
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_s_wren", {31'd0, s_wren}, 32'd0);
        check("reset_ct_wren", {31'd0, ct_wren}, 32'd0);
        check("reset_s_addr", {24'd0, s_addr}, 32'd0);
        check("reset_ct_wrdata", {24'd0, ct_wrdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // One byte over identity S: pad = S[2] = 2.
        s_identity(); ct_clear();
        pt_mem[0] = 8'd1; pt_mem[1] = 8'h41;
        run("one_byte", -1);
        check("one_byte_ct0", {24'd0, ct_mem[0]}, 32'h01);
        check("one_byte_ct1", {24'd0, ct_mem[1]}, 32'h43);
        check("one_byte_s1", {24'd0, s_mem[1]}, 32'h01);

        // Empty message: only the length byte, no S traffic.
        s_identity(); ct_clear();
        pt_mem[0] = 8'd0;
        wr0 = s_wr_count;
        run("empty", -1);
        check("empty_ct0", {24'd0, ct_mem[0]}, 32'h00);
        check("empty_ct1_untouched", {24'd0, ct_mem[1]}, 32'hEE);
        check("empty_s_wren", 32'(s_wr_count - wr0), 32'd0);

        // Two bytes: second byte swaps S[2]/S[3] and pads with S[5].
        s_identity(); ct_clear();
        pt_mem[0] = 8'd2; pt_mem[1] = 8'h00; pt_mem[2] = 8'h00;
        run("two_byte", -1);
        check("two_byte_ct1", {24'd0, ct_mem[1]}, 32'h02);
        check("two_byte_ct2", {24'd0, ct_mem[2]}, 32'h05);
        check("two_byte_s2", {24'd0, s_mem[2]}, 32'h03);
        check("two_byte_s3", {24'd0, s_mem[3]}, 32'h02);
        check("two_byte_ct3_untouched", {24'd0, ct_mem[3]}, 32'hEE);

        // en pulsed while busy must not disturb timing or data.
        s_identity(); ct_clear();
        pt_mem[0] = 8'd3;
        for (int x = 1; x <= 3; x++) pt_mem[x] = 8'($urandom_range(0, 255));
        run("busy_en", 5);

        // Asynchronous reset in the middle of a message.
        ksa_model(24'h00_00_18); ct_clear();
        pt_mem[0] = 8'd20;
        for (int x = 1; x <= 20; x++) pt_mem[x] = 8'($urandom_range(0, 255));
        predict();
        start("abort");
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_rdy", {31'd0, rdy}, 32'd1);
        check("abort_s_wren", {31'd0, s_wren}, 32'd0);
        check("abort_ct_wren", {31'd0, ct_wren}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_identity(); ct_clear();
        pt_mem[0] = 8'd1; pt_mem[1] = 8'h41;
        run("after_abort", -1);
        check("after_abort_ct1", {24'd0, ct_mem[1]}, 32'h43);

        // Full-length round trip against an independent software decrypt.
        ksa_model(24'h00_00_18); ct_clear();
        pt_mem[0] = 8'd255;
        for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom_range(0, 255));
        run("round_trip", -1);
        check("round_trip_len", {24'd0, ct_mem[0]}, 32'd255);
        ksa_model(24'h00_00_18);
        i = 8'd0; j = 8'd0; bad = 0;
        for (int k = 1; k < 256; k++) begin
            i = 8'(i + 8'd1);
            j = 8'(j + s_mem[i]);
            t = s_mem[i]; s_mem[i] = s_mem[j]; s_mem[j] = t;
            pad = s_mem[8'(s_mem[i] + s_mem[j])];
            if ((ct_mem[k] ^ pad) !== pt_mem[k]) bad++;
        end
        check("round_trip_decrypt", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
